// File: rtl/latch_wr_pkg.sv
// Shared types and sizing helpers for the latch bank write sequencer.
// Build option: define LATCH_WR_PARITY_EN to append an even-parity bit to the latch D bus.
package latch_wr_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    localparam int DEF_WIDTH = 8;

`ifdef LATCH_WR_PARITY_EN
    localparam int PARITY_W = 1;
`else
    localparam int PARITY_W = 0;
`endif

    // Width of the shared latch D bus for a given data width.
    function automatic int lat_d_width(input int w);
        return w + PARITY_W;
    endfunction

    localparam int LAT_D_W = lat_d_width(DEF_WIDTH);

    // Down-counter width large enough for the longest phase, never below one bit.
    function automatic int cnt_width(input int open_c, input int hold_c, input int clr_c);
        int m;
        int w;
        m = open_c;
        if (hold_c > m) m = hold_c;
        if (clr_c > m) m = clr_c;
        w = $clog2(m + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/latch_wr_decoder.sv
// Purely combinational one-hot word-enable decode with address range check.
// Out-of-range addresses produce an all-zero enable vector.
module latch_wr_decoder
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
)
(
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DEPTH-1:0]  o_onehot,
    output logic              o_in_range
);

    // Decode the captured address into at most one enable bit.
    always_comb begin
        o_onehot   = '0;
        o_in_range = (int'(i_addr) < DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(i_addr) == i) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer driving the D/E/RN pins of a latch bank: D settles one cycle before
// E rises, E is held for OPEN_CYCLES, D is held HOLD_CYCLES after E falls, and a bank
// clear holds RN low for CLR_CYCLES followed by a one-cycle RN recovery gap.
// Build option: define LATCH_WR_PARITY_EN to widen lat_d by one even-parity bit.
// ADDR_W may be widened beyond $clog2(DEPTH) when the upstream address bus is wider
// than the bank; such addresses are accepted, run full timing and flag wr_err.
module latch_bank_wr_ctrl
    import latch_wr_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int WIDTH       = 8,
    parameter int OPEN_CYCLES = 2,
    parameter int HOLD_CYCLES = 1,
    parameter int CLR_CYCLES  = 2,
    parameter int ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
)
(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [WIDTH-1:0]              i_wr_data,
    output logic                          o_wr_err,
    input  logic                          i_clr_req,
    output logic                          o_clr_ack,
    output logic [lat_d_width(WIDTH)-1:0] o_lat_d,
    output logic [DEPTH-1:0]              o_lat_e,
    output logic                          o_lat_rn,
    output logic                          o_busy
);

    localparam int LDW   = lat_d_width(WIDTH);
    localparam int CNT_W = cnt_width(OPEN_CYCLES, HOLD_CYCLES, CLR_CYCLES);

    localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [LDW-1:0]      r_lat_d;
    logic [DEPTH-1:0]    r_lat_e;
    logic                r_lat_rn;
    logic                r_wr_err;
    logic                r_clr_ack;
    logic                r_busy;

    logic [DEPTH-1:0]    w_onehot;
    logic                w_in_range;
    logic                w_wr_ready;
    logic [LDW-1:0]      w_lat_d_next;

    latch_wr_decoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_decoder (
        .i_addr     (r_addr),
        .o_onehot   (w_onehot),
        .o_in_range (w_in_range)
    );

    // Data word as presented to the latches, with parity appended when enabled.
`ifdef LATCH_WR_PARITY_EN
    assign w_lat_d_next = {^i_wr_data, i_wr_data};
`else
    assign w_lat_d_next = i_wr_data;
`endif

    // Only combinational output: accept writes in IDLE once the bank is out of clear
    // and no clear is pending, so a clear request always wins over a write.
    assign w_wr_ready = (r_state == ST_IDLE) && r_lat_rn && !i_clr_req;

    // Sequencer FSM: phase counters reload on every state entry and count down to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_lat_d   <= '0;
            r_lat_e   <= '0;
            r_lat_rn  <= 1'b0;
            r_wr_err  <= 1'b0;
            r_clr_ack <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_wr_err  <= 1'b0;
            r_clr_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_lat_rn) begin
                        r_lat_rn <= 1'b1;
                    end else if (i_clr_req) begin
                        r_state  <= ST_CLEAR;
                        r_lat_rn <= 1'b0;
                        r_lat_e  <= '0;
                        r_cnt    <= CLR_LOAD;
                        r_busy   <= 1'b1;
                    end else if (i_wr_valid && w_wr_ready) begin
                        r_state <= ST_SETUP;
                        r_lat_d <= w_lat_d_next;
                        r_addr  <= i_wr_addr;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_state  <= ST_OPEN;
                    r_lat_e  <= w_onehot;
                    r_wr_err <= !w_in_range;
                    r_cnt    <= OPEN_LOAD;
                end
                ST_OPEN: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_HOLD;
                        r_lat_e <= '0;
                        r_cnt   <= HOLD_LOAD;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == '0) begin
                        r_state  <= ST_RECOVER;
                        r_lat_rn <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_RECOVER: begin
                    r_state   <= ST_IDLE;
                    r_clr_ack <= 1'b1;
                    r_cnt     <= '0;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_lat_e  <= '0;
                    r_lat_rn <= 1'b0;
                    r_cnt    <= '0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_ready = w_wr_ready;
    assign o_wr_err   = r_wr_err;
    assign o_clr_ack  = r_clr_ack;
    assign o_lat_d    = r_lat_d;
    assign o_lat_e    = r_lat_e;
    assign o_lat_rn   = r_lat_rn;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Self-checking bench for latch_bank_wr_ctrl (DEPTH=8, WIDTH=8, OPEN=2, HOLD=1, CLR=2).
// A 4-bit address bus is used so out-of-range addresses can be driven.
// Build option: define LATCH_WR_PARITY_EN to check the parity-extended D bus.
module tb_latch_bank_wr_ctrl;

`ifdef LATCH_WR_PARITY_EN
    localparam int LDW = 9;
`else
    localparam int LDW = 8;
`endif

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] expE;
        logic       expErr;
    } vec_t;

    logic           clk;
    logic           rstN;
    logic           wrValid;
    logic           wrReady;
    logic [3:0]     wrAddr;
    logic [7:0]     wrData;
    logic           wrErr;
    logic           clrReq;
    logic           clrAck;
    logic [LDW-1:0] latD;
    logic [7:0]     latE;
    logic           latRn;
    logic           busy;

    int             testsRun;
    int             testsFailed;
    logic [LDW-1:0] lastLatD;
    vec_t           vecs [7];

    latch_bank_wr_ctrl #(
        .DEPTH       (8),
        .WIDTH       (8),
        .OPEN_CYCLES (2),
        .HOLD_CYCLES (1),
        .CLR_CYCLES  (2),
        .ADDR_W      (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_wr_valid (wrValid),
        .o_wr_ready (wrReady),
        .i_wr_addr  (wrAddr),
        .i_wr_data  (wrData),
        .o_wr_err   (wrErr),
        .i_clr_req  (clrReq),
        .o_clr_ack  (clrAck),
        .o_lat_d    (latD),
        .o_lat_e    (latE),
        .o_lat_rn   (latRn),
        .o_busy     (busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected latch D bus for a data byte.
    function automatic logic [LDW-1:0] expLatD(input logic [7:0] d);
`ifdef LATCH_WR_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all request inputs together.
    task automatic applyStimulus(input logic v, input logic c, input logic [3:0] a, input logic [7:0] d);
        wrValid = v;
        clrReq  = c;
        wrAddr  = a;
        wrData  = d;
    endtask

    // Compare one observed value with its expected value and tally the result.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one write from IDLE and check the full D/E waveform edge by edge.
    task automatic runWrite(input string name, input logic [3:0] a, input logic [7:0] d,
                            input logic [7:0] expE, input logic expErr);
        logic [LDW-1:0] expD;
        expD = expLatD(d);
        applyStimulus(1'b1, 1'b0, a, d);
        checkOutput({name, "_ready_k"}, 32'(wrReady), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, ~a, ~d);
        checkOutput({name, "_latD_k"}, 32'(latD), 32'(expD));
        checkOutput({name, "_latE_k"}, 32'(latE), 32'h0);
        checkOutput({name, "_busy_k"}, 32'(busy), 32'd1);
        checkOutput({name, "_ready_busy"}, 32'(wrReady), 32'd0);
        tick();
        checkOutput({name, "_latE_k1"}, 32'(latE), 32'(expE));
        checkOutput({name, "_err_k1"}, 32'(wrErr), 32'(expErr));
        tick();
        checkOutput({name, "_latE_k2"}, 32'(latE), 32'(expE));
        checkOutput({name, "_err_k2"}, 32'(wrErr), 32'd0);
        checkOutput({name, "_latD_k2"}, 32'(latD), 32'(expD));
        tick();
        checkOutput({name, "_latE_k3"}, 32'(latE), 32'h0);
        checkOutput({name, "_latD_k3"}, 32'(latD), 32'(expD));
        checkOutput({name, "_busy_k3"}, 32'(busy), 32'd1);
        tick();
        checkOutput({name, "_busy_k4"}, 32'(busy), 32'd0);
        checkOutput({name, "_ready_k4"}, 32'(wrReady), 32'd1);
        lastLatD = expD;
    endtask

    // Main sequence: reset, table-driven writes, then multi-cycle corner cases.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        lastLatD    = '0;
        rstN        = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);

        vecs[0] = '{addr: 4'd3,  data: 8'hA5, expE: 8'h08, expErr: 1'b0};
        vecs[1] = '{addr: 4'd0,  data: 8'h3C, expE: 8'h01, expErr: 1'b0};
        vecs[2] = '{addr: 4'd7,  data: 8'hFF, expE: 8'h80, expErr: 1'b0};
        vecs[3] = '{addr: 4'd9,  data: 8'h5A, expE: 8'h00, expErr: 1'b1};
        vecs[4] = '{addr: 4'd5,  data: 8'h07, expE: 8'h20, expErr: 1'b0};
        vecs[5] = '{addr: 4'd8,  data: 8'h01, expE: 8'h00, expErr: 1'b1};
        vecs[6] = '{addr: 4'd15, data: 8'h80, expE: 8'h00, expErr: 1'b1};

        tick();
        tick();
        checkOutput("rst_latRn", 32'(latRn), 32'd0);
        checkOutput("rst_latE", 32'(latE), 32'h0);
        checkOutput("rst_latD", 32'(latD), 32'h0);
        checkOutput("rst_ready", 32'(wrReady), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(wrErr), 32'd0);
        checkOutput("rst_ack", 32'(clrAck), 32'd0);
        rstN = 1'b1;
        #1;
        checkOutput("rel_latRn_pre", 32'(latRn), 32'd0);
        checkOutput("rel_ready_pre", 32'(wrReady), 32'd0);
        tick();
        checkOutput("rel_latRn", 32'(latRn), 32'd1);
        checkOutput("rel_ready", 32'(wrReady), 32'd1);
        checkOutput("rel_latE", 32'(latE), 32'h0);
        checkOutput("rel_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            runWrite($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].expE, vecs[i].expErr);
        end

        // Clear and write requested together: clear wins, write follows.
        applyStimulus(1'b1, 1'b1, 4'd2, 8'h33);
        #1;
        checkOutput("cw_ready_pri", 32'(wrReady), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 4'd2, 8'h33);
        checkOutput("cw_latRn_c0", 32'(latRn), 32'd0);
        checkOutput("cw_busy_c0", 32'(busy), 32'd1);
        checkOutput("cw_latD_c0", 32'(latD), 32'(lastLatD));
        tick();
        checkOutput("cw_latRn_c1", 32'(latRn), 32'd0);
        checkOutput("cw_ready_c1", 32'(wrReady), 32'd0);
        tick();
        checkOutput("cw_latRn_rec", 32'(latRn), 32'd1);
        checkOutput("cw_ack_rec", 32'(clrAck), 32'd0);
        checkOutput("cw_latE_rec", 32'(latE), 32'h0);
        checkOutput("cw_busy_rec", 32'(busy), 32'd1);
        tick();
        checkOutput("cw_ack", 32'(clrAck), 32'd1);
        checkOutput("cw_busy_idle", 32'(busy), 32'd0);
        checkOutput("cw_latD_kept", 32'(latD), 32'(lastLatD));
        runWrite("cw_write", 4'd2, 8'h33, 8'h04, 1'b0);

        // Clear raised during OPEN: write finishes, then level-held clear repeats.
        applyStimulus(1'b1, 1'b0, 4'd1, 8'h96);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("co_latE_k1", 32'(latE), 32'h02);
        applyStimulus(1'b0, 1'b1, 4'd0, 8'h00);
        tick();
        checkOutput("co_latE_k2", 32'(latE), 32'h02);
        checkOutput("co_latRn_k2", 32'(latRn), 32'd1);
        tick();
        checkOutput("co_latE_hold", 32'(latE), 32'h0);
        checkOutput("co_latRn_hold", 32'(latRn), 32'd1);
        checkOutput("co_latD_hold", 32'(latD), 32'(expLatD(8'h96)));
        tick();
        checkOutput("co_busy_idle", 32'(busy), 32'd0);
        checkOutput("co_latRn_idle", 32'(latRn), 32'd1);
        checkOutput("co_ready_clr", 32'(wrReady), 32'd0);
        tick();
        checkOutput("co_latRn_c0", 32'(latRn), 32'd0);
        tick();
        checkOutput("co_latRn_c1", 32'(latRn), 32'd0);
        tick();
        checkOutput("co_latRn_rec", 32'(latRn), 32'd1);
        checkOutput("co_ack_rec", 32'(clrAck), 32'd0);
        tick();
        checkOutput("co_ack1", 32'(clrAck), 32'd1);
        tick();
        checkOutput("lv_latRn_again", 32'(latRn), 32'd0);
        checkOutput("lv_ack_drop", 32'(clrAck), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("lv_latRn_c1", 32'(latRn), 32'd0);
        tick();
        checkOutput("lv_latRn_rec", 32'(latRn), 32'd1);
        tick();
        checkOutput("lv_ack2", 32'(clrAck), 32'd1);
        tick();
        checkOutput("lv_ack2_drop", 32'(clrAck), 32'd0);
        checkOutput("lv_ready", 32'(wrReady), 32'd1);
        checkOutput("lv_latD_kept", 32'(latD), 32'(expLatD(8'h96)));

        // Reset asserted during OPEN returns everything to reset values at once.
        applyStimulus(1'b1, 1'b0, 4'd6, 8'hC3);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("rn_latE_open", 32'(latE), 32'h40);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rn_latE", 32'(latE), 32'h0);
        checkOutput("rn_latRn", 32'(latRn), 32'd0);
        checkOutput("rn_busy", 32'(busy), 32'd0);
        checkOutput("rn_latD", 32'(latD), 32'h0);
        checkOutput("rn_ready", 32'(wrReady), 32'd0);
        tick();
        rstN = 1'b1;
        #1;
        checkOutput("rn_rel_latRn_pre", 32'(latRn), 32'd0);
        tick();
        checkOutput("rn_rel_latRn", 32'(latRn), 32'd1);
        runWrite("rn_after", 4'd4, 8'h81, 8'h10, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
